// File: rtl/opcode_storage_engine.sv
// opcode_storage_engine: executes the 4-bit opcodes issued by the
// BUFFER/FIFO/LIFO controller. It holds one FIFO and one LIFO of DEPTH words
// each and returns read/pass-through data, occupancy, flags and an error pulse.
module opcode_storage_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              lifo_full,
    output logic              lifo_empty,
    output logic [AW:0]       fifo_count,
    output logic [AW:0]       lifo_count,
    output logic              err
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    // Opcode encodings: [3:2] target, [1:0] action
    localparam logic [3:0] OP_BUFFER  = 4'b01_00;
    localparam logic [3:0] OP_F_WRITE = 4'b10_01;
    localparam logic [3:0] OP_F_READ  = 4'b10_10;
    localparam logic [3:0] OP_L_PUSH  = 4'b11_01;
    localparam logic [3:0] OP_L_POP   = 4'b11_10;
    localparam logic [3:0] OP_F_BLOCK = 4'b10_00;
    localparam logic [3:0] OP_L_BLOCK = 4'b11_00;

    // Storage arrays (contents intentionally survive reset)
    logic [DATA_W-1:0] mem_f [DEPTH];
    logic [DATA_W-1:0] mem_l [DEPTH];

    // Registered state
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [AW-1:0]     fifo_wp_q, fifo_wp_d;
    logic [AW-1:0]     fifo_rp_q, fifo_rp_d;
    logic [AW:0]       fifo_count_q, fifo_count_d;
    logic [AW:0]       lifo_sp_q, lifo_sp_d;
    logic              fifo_full_q, fifo_full_d;
    logic              fifo_empty_q, fifo_empty_d;
    logic              lifo_full_q, lifo_full_d;
    logic              lifo_empty_q, lifo_empty_d;

    // Memory write strobes and addresses
    logic              fifo_we_s;
    logic              lifo_we_s;
    logic [AW:0]       lifo_top_s;
    logic [AW-1:0]     lifo_wr_idx_s;
    logic [AW-1:0]     lifo_rd_idx_s;

    assign lifo_top_s    = lifo_sp_q - CNT_ONE;
    assign lifo_wr_idx_s = lifo_sp_q[AW-1:0];
    assign lifo_rd_idx_s = lifo_top_s[AW-1:0];

    // Opcode decode and next-state computation for both stores and outputs
    always_comb begin
        data_out_d   = data_out_q;
        out_valid_d  = 1'b0;
        err_d        = 1'b0;
        fifo_wp_d    = fifo_wp_q;
        fifo_rp_d    = fifo_rp_q;
        fifo_count_d = fifo_count_q;
        lifo_sp_d    = lifo_sp_q;
        fifo_we_s    = 1'b0;
        lifo_we_s    = 1'b0;

        if (op_valid) begin
            case (opcode)
                OP_BUFFER: begin
                    data_out_d  = data_in;
                    out_valid_d = 1'b1;
                end
                OP_F_WRITE: begin
                    if (!fifo_full_q) begin
                        fifo_we_s    = 1'b1;
                        fifo_wp_d    = fifo_wp_q + PTR_ONE;
                        fifo_count_d = fifo_count_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_F_READ: begin
                    if (!fifo_empty_q) begin
                        data_out_d   = mem_f[fifo_rp_q];
                        out_valid_d  = 1'b1;
                        fifo_rp_d    = fifo_rp_q + PTR_ONE;
                        fifo_count_d = fifo_count_q - CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_L_PUSH: begin
                    if (!lifo_full_q) begin
                        lifo_we_s = 1'b1;
                        lifo_sp_d = lifo_sp_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_L_POP: begin
                    if (!lifo_empty_q) begin
                        data_out_d  = mem_l[lifo_rd_idx_s];
                        out_valid_d = 1'b1;
                        lifo_sp_d   = lifo_top_s;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_F_BLOCK, OP_L_BLOCK: begin
                    // Controller saw read and write together
                    err_d = 1'b1;
                end
                default: begin
                    // Undefined codes, including X/Z while the controller resets
                    err_d = 1'b1;
                end
            endcase
        end else begin
            out_valid_d = 1'b0;
        end

        fifo_full_d  = (fifo_count_d == CNT_DEPTH);
        fifo_empty_d = (fifo_count_d == CNT_ZERO);
        lifo_full_d  = (lifo_sp_d == CNT_DEPTH);
        lifo_empty_d = (lifo_sp_d == CNT_ZERO);
    end

    // Control, pointer, flag and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            fifo_wp_q    <= '0;
            fifo_rp_q    <= '0;
            fifo_count_q <= '0;
            lifo_sp_q    <= '0;
            fifo_full_q  <= 1'b0;
            fifo_empty_q <= 1'b1;
            lifo_full_q  <= 1'b0;
            lifo_empty_q <= 1'b1;
        end else begin
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            fifo_wp_q    <= fifo_wp_d;
            fifo_rp_q    <= fifo_rp_d;
            fifo_count_q <= fifo_count_d;
            lifo_sp_q    <= lifo_sp_d;
            fifo_full_q  <= fifo_full_d;
            fifo_empty_q <= fifo_empty_d;
            lifo_full_q  <= lifo_full_d;
            lifo_empty_q <= lifo_empty_d;
        end
    end

    // Storage writes; no reset so stored words are retained
    always_ff @(posedge clk) begin
        if (fifo_we_s) begin
            mem_f[fifo_wp_q] <= data_in;
        end
        if (lifo_we_s) begin
            mem_l[lifo_wr_idx_s] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign fifo_full  = fifo_full_q;
    assign fifo_empty = fifo_empty_q;
    assign lifo_full  = lifo_full_q;
    assign lifo_empty = lifo_empty_q;
    assign fifo_count = fifo_count_q;
    assign lifo_count = lifo_sp_q;

endmodule

// File: doc/opcode_storage_engine.md
Name: opcode_storage_engine

Overview:
- Execution end of the BUFFER/FIFO/LIFO controller. It consumes the 4-bit opcode that the controller produces and performs the requested operation.
- Operations: buffer pass-through, FIFO write/read, LIFO push/pop.
- Holds two independent DEPTH-entry stores, one FIFO and one LIFO.
- Reports data, occupancy, full/empty and per-operation error status back to the system.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 8, entries per store; power of two, minimum 2. Derived localparam AW = log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  qualifies opcode; exactly one operation executes per clk edge where op_valid=1
opcode  input  4  operation code: [3:2] = target, [1:0] = action
data_in  input  DATA_W  write / pass-through data
data_out  output  DATA_W  registered read / pass-through result
out_valid  output  1  one-cycle pulse: data_out was updated this cycle
fifo_full  output  1  fifo_count == DEPTH
fifo_empty  output  1  fifo_count == 0
lifo_full  output  1  lifo_count == DEPTH
lifo_empty  output  1  lifo_count == 0
fifo_count  output  AW+1  FIFO occupancy, 0..DEPTH
lifo_count  output  AW+1  LIFO occupancy, 0..DEPTH
err  output  1  one-cycle pulse: the operation was rejected

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - data_out = 0, out_valid = 0, err = 0.
  - Both counts = 0; FIFO write/read pointers = 0; LIFO stack pointer = 0.
  - Storage contents are not cleared.
- op_valid = 0: no state change; out_valid = 0 and err = 0 on the next edge.
- Decode on rising clk when op_valid = 1. No operation is pending across cycles.
  - 01_00 BUFFER: data_out <= data_in; out_valid = 1. Stores untouched.
  - 10_01 FIFO write:
    - if !fifo_full: mem_f[wp] <= data_in; wp increments modulo DEPTH (wraps); count +1.
    - else err = 1; no change.
  - 10_10 FIFO read:
    - if !fifo_empty: data_out <= mem_f[rp]; rp increments modulo DEPTH; count -1; out_valid = 1.
    - else err = 1; data_out holds.
  - 11_01 LIFO push:
    - if !lifo_full: mem_l[sp] <= data_in; sp +1.
    - else err = 1.
  - 11_10 LIFO pop:
    - if !lifo_empty: data_out <= mem_l[sp-1]; sp -1; out_valid = 1.
    - else err = 1.
  - 10_00 / 11_00 BLOCKED (controller saw read and write together): err = 1; no state change.
  - Any other code, including X/Z from the controller's reset state: err = 1; no state change.
- Latency: read and buffer data appear on data_out one clock after the accepting edge, coincident with the out_valid pulse.
- Flags: full, empty and count are registered and reflect all operations completed up to the last edge.
- Throughput: one operation per cycle, back-to-back allowed.
  - A FIFO write followed immediately by a read of the same slot returns the new data.
  - LIFO push then pop on consecutive cycles returns the pushed word.
- FIFO and LIFO state are fully independent; an operation on one never alters the other's counts or flags.
- err and out_valid are never both 1 in the same cycle.

Test Plan:
1. Assert reset mid-run with both stores partly full → same cycle, before any clock edge: counts = 0, fifo_empty = lifo_empty = 1, full flags = 0, data_out = 0x00, out_valid = err = 0.
2. FIFO write 0x11, 0x22, 0x33, then 3 reads back-to-back → data_out 0x11, 0x22, 0x33 on successive cycles, out_valid high for each; fifo_count 3 → 0; fifo_empty = 1 at end.
3. LIFO push 0xA1, 0xA2, 0xA3, then 3 pops → data_out 0xA3, 0xA2, 0xA1; lifo_count 3 → 0; fifo_count remains 0 throughout.
4. Write 8 words 0x00..0x07 to FIFO → fifo_full = 1. A 9th write of 0xFF → err pulse, count stays 8. Then read 3 (0x00..0x02), write 0x08..0x0A (pointer wrap), read 8 → 0x03..0x0A in order.
5. Pop empty LIFO, read empty FIFO, issue 10_00 and 4'b1111 → err = 1 each cycle; out_valid = 0; data_out holds its previous value; counts unchanged.
6. BUFFER 01_00 with data_in = 0x5A while FIFO holds 2 entries → data_out = 0x5A next cycle, out_valid = 1, fifo_count stays 2. With op_valid = 0 and opcode = 10_10, nothing changes.
